// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl - program-counter sequencer for the core fetch stage.
//
// Holds the D-bit program counter. In RUN it advances the PC each cycle or
// loads an absolute branch target. Prog_ctr drives the instruction ROM address.
//
// Optional feature macro: PC_CALL_STACK_EN
//   When it is defined, a DEPTH-entry return-address stack is added for
//   Call/Ret. When it is undefined, Call and Ret are ignored and StackErr
//   is tied to 0.
//
// Ports
//   Clk       in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   Start     in   begin execution (sampled in IDLE/DONE only)
//   Stall     in   hold PC this cycle (RUN only)
//   Halt      in   stop fetching, go to DONE (RUN only)
//   Jump      in   taken branch, load Target
//   Target    in   absolute branch target [D-1:0]
//   Call      in   push return address and load Target (stack build)
//   Ret       in   load popped return address (stack build)
//   Prog_ctr  out  registered PC / ROM address [D-1:0]
//   Running   out  1 while in RUN
//   Done      out  1 while in DONE
//   StackErr  out  sticky stack over/underflow flag
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | after reset, waiting for Start
// RUN   | fetching; PC advances, jumps, stalls
// DONE  | program ended by Halt, waiting for Start

module pc_fetch_ctrl #(
    parameter int             D          = 10,
    parameter logic [D-1:0]   START_ADDR = '0,
    parameter int             DEPTH      = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Stall,
    input  logic         Halt,
    input  logic         Jump,
    input  logic [D-1:0] Target,
    input  logic         Call,
    input  logic         Ret,
    output logic [D-1:0] Prog_ctr,
    output logic         Running,
    output logic         Done,
    output logic         StackErr
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t       state, state_nxt;
    logic [D-1:0] pc_nxt;
    logic [D-1:0] pc_inc;

    assign pc_inc = Prog_ctr + 1'b1;   // natural wrap modulo 2^D

`ifdef PC_CALL_STACK_EN
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = $clog2(DEPTH + 1);

    logic [D-1:0]   stack [DEPTH];
    logic [SPW-1:0] sp, sp_nxt, sp_m1;
    logic           err_nxt;
    logic           push_en;

    assign sp_m1 = sp - 1'b1;
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = DEPTH + {30'd0, Call, Ret};
    assign StackErr   = 1'b0;
`endif

    // state and datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            Prog_ctr <= '0;
            Running  <= 1'b0;
            Done     <= 1'b0;
`ifdef PC_CALL_STACK_EN
            sp       <= '0;
            StackErr <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            Prog_ctr <= pc_nxt;
            Running  <= (state_nxt == RUN);
            Done     <= (state_nxt == DONE);
`ifdef PC_CALL_STACK_EN
            sp       <= sp_nxt;
            StackErr <= err_nxt;
`endif
        end
    end

`ifdef PC_CALL_STACK_EN
    // Entries above sp are dead, so the storage itself needs no reset.
    always_ff @(posedge Clk) begin
        if (push_en)
            stack[sp[AW-1:0]] <= pc_inc;
    end
`endif

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (Start) state_nxt = RUN;
            RUN:        if (Halt)  state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // datapath / output next values
    always_comb begin
        pc_nxt = Prog_ctr;
`ifdef PC_CALL_STACK_EN
        sp_nxt  = sp;
        err_nxt = StackErr;
        push_en = 1'b0;
`endif
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    pc_nxt = START_ADDR;
`ifdef PC_CALL_STACK_EN
                    sp_nxt  = '0;
                    err_nxt = 1'b0;
`endif
                end
            end
            RUN: begin
                if (Halt || Stall) begin
                    pc_nxt = Prog_ctr;
`ifdef PC_CALL_STACK_EN
                end else if (Ret) begin
                    if (sp != '0) begin
                        pc_nxt = stack[sp_m1[AW-1:0]];
                        sp_nxt = sp_m1;
                    end else begin
                        // A return with nothing to pop falls through to increment.
                        pc_nxt  = pc_inc;
                        err_nxt = 1'b1;
                    end
                end else if (Call) begin
                    // On overflow the call still jumps; the return address is lost.
                    pc_nxt = Target;
                    if (sp != SPW'(DEPTH)) begin
                        push_en = 1'b1;
                        sp_nxt  = sp + 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
`endif
                end else if (Jump) begin
                    pc_nxt = Target;
                end else begin
                    pc_nxt = pc_inc;
                end
            end
            default: pc_nxt = '0;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    localparam int D     = 10;
    localparam int START = 0;
    localparam int MODV  = 1 << D;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Start = 0, Stall = 0, Halt = 0, Jump = 0, Call = 0, Ret = 0;
    logic [D-1:0] Target = '0;
    logic [D-1:0] Prog_ctr;
    logic         Running, Done, StackErr;

    int n_checks = 0;
    int n_pass   = 0;

    pc_fetch_ctrl #(.D(D), .START_ADDR(START[D-1:0]), .DEPTH(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
        .Jump(Jump), .Target(Target), .Call(Call), .Ret(Ret),
        .Prog_ctr(Prog_ctr), .Running(Running), .Done(Done), .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit       start, stall, halt, jump;
        int       target;
        int       pc;
        bit       run, done;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input bit st, sl, hl, jp, input int tg, pc, input bit rn, dn);
        vec_t v;
        v.start = st; v.stall = sl; v.halt = hl; v.jump = jp;
        v.target = tg; v.pc = pc; v.run = rn; v.done = dn;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cyc(input bit st, sl, hl, jp, cl, rt, input int tg);
        @(negedge Clk);
        Start = st; Stall = sl; Halt = hl; Jump = jp; Call = cl; Ret = rt;
        Target = tg[D-1:0];
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        {Start, Stall, Halt, Jump, Call, Ret} = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Behavioural reference: mode 0=idle, 1=run, 2=done
    int m_mode, m_pc;
    bit m_err;
    int m_stk[$];

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_err = 0; m_stk.delete();
    endtask

    task automatic model_step(input bit st, sl, hl, jp, cl, rt, input int tg);
        if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = START; m_err = 0; m_stk.delete();
            end
        end else if (hl) begin
            m_mode = 2;
        end else if (sl) begin
            m_pc = m_pc;
`ifdef PC_CALL_STACK_EN
        end else if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = (m_pc + 1) % MODV; m_err = 1; end
        end else if (cl) begin
            if (m_stk.size() < 4) m_stk.push_back((m_pc + 1) % MODV);
            else m_err = 1;
            m_pc = tg;
`endif
        end else if (jp) begin
            m_pc = tg;
        end else begin
            m_pc = (m_pc + 1) % MODV;
        end
    endtask

    initial begin
        // table: starts right after reset
        addv(1,0,0,0,   0,    0, 1, 0);
        addv(0,0,0,0,   0,    1, 1, 0);
        addv(0,0,0,0,   0,    2, 1, 0);
        addv(0,0,0,0,   0,    3, 1, 0);
        addv(0,0,0,0,   0,    4, 1, 0);
        addv(0,0,0,0,   0,    5, 1, 0);
        addv(0,1,0,1,  59,    5, 1, 0);
        addv(0,0,0,1,  59,   59, 1, 0);
        addv(0,0,0,0,   0,   60, 1, 0);
        addv(0,0,0,1,1023, 1023, 1, 0);
        addv(0,0,0,0,   0,    0, 1, 0);
        addv(0,0,0,0,   0,    1, 1, 0);
        addv(0,0,0,0,   0,    2, 1, 0);
        addv(0,0,1,1, 500,    2, 0, 1);
        addv(0,0,0,0,   0,    2, 0, 1);
        addv(0,1,0,1,   7,    2, 0, 1);
        addv(1,0,0,0,   0,    0, 1, 0);
        addv(1,0,0,0,   0,    1, 1, 0);
        addv(0,1,1,0,   0,    1, 0, 1);
        addv(1,0,0,1,   9,    0, 1, 0);
        addv(0,0,0,1,   9,    9, 1, 0);

        #2;
        check("reset_pc", int'(Prog_ctr), 0);
        check("reset_running", int'(Running), 0);
        check("reset_done", int'(Done), 0);
        check("reset_stackerr", int'(StackErr), 0);
        do_reset();

        foreach (vecs[i]) begin
            cyc(vecs[i].start, vecs[i].stall, vecs[i].halt, vecs[i].jump, 0, 0, vecs[i].target);
            check($sformatf("vec%0d_pc", i), int'(Prog_ctr), vecs[i].pc);
            check($sformatf("vec%0d_running", i), int'(Running), int'(vecs[i].run));
            check($sformatf("vec%0d_done", i), int'(Done), int'(vecs[i].done));
        end

        // async reset mid-run at PC=37
        cyc(0,0,0,1,0,0,37);
        check("pre_reset_pc", int'(Prog_ctr), 37);
        #2 Reset_n = 1'b0;
        #1;
        check("async_reset_pc", int'(Prog_ctr), 0);
        check("async_reset_running", int'(Running), 0);
        check("async_reset_done", int'(Done), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        {Start, Stall, Halt, Jump, Call, Ret} = '0;
        repeat (3) cyc(0,0,0,1,0,0,55);
        check("idle_hold_pc", int'(Prog_ctr), 0);
        check("idle_hold_running", int'(Running), 0);
        cyc(1,0,0,0,0,0,0);
        check("restart_running", int'(Running), 1);

        cyc(0,0,0,1,0,0,10);
`ifdef PC_CALL_STACK_EN
        cyc(0,0,0,0,1,0,202);
        check("call_pc", int'(Prog_ctr), 202);
        cyc(0,0,0,0,0,1,0);
        check("ret_pc", int'(Prog_ctr), 11);
        for (int k = 0; k < 5; k++) cyc(0,0,0,0,1,0,100 + k);
        check("overflow_call_pc", int'(Prog_ctr), 104);
        check("overflow_err", int'(StackErr), 1);
        cyc(0,0,0,0,0,1,0);
        check("pop1_pc", int'(Prog_ctr), 103);
        repeat (2) cyc(0,0,0,0,0,1,0);
        cyc(0,0,0,0,0,1,0);
        check("pop4_pc", int'(Prog_ctr), 12);
        cyc(0,0,0,0,0,1,0);
        check("underflow_pc", int'(Prog_ctr), 13);
        check("underflow_err", int'(StackErr), 1);
`else
        cyc(0,0,0,0,1,0,202);
        check("call_ignored_pc", int'(Prog_ctr), 11);
        check("call_ignored_err", int'(StackErr), 0);
        cyc(0,0,0,0,0,1,300);
        check("ret_ignored_pc", int'(Prog_ctr), 12);
`endif

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            bit st, sl, hl, jp, cl, rt;
            int tg;
            st = ($urandom_range(0, 15) == 0);
            sl = ($urandom_range(0, 3) == 0);
            hl = ($urandom_range(0, 31) == 0);
            jp = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 7) == 0);
            tg = $urandom_range(0, MODV - 1);
            if (n < 2) st = 1;
            cyc(st, sl, hl, jp, cl, rt, tg);
            model_step(st, sl, hl, jp, cl, rt, tg);
            check("rand_pc", int'(Prog_ctr), m_pc);
            check("rand_running", int'(Running), int'(m_mode == 1));
            check("rand_done", int'(Done), int'(m_mode == 2));
            check("rand_stackerr", int'(StackErr), int'(m_err));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
